// File: rtl/spectrogram_col_writer.sv
`timescale 1ns/1ps
// FFT stream -> approximate-magnitude column writer for the 512 x 10-bit spectrogram RAM.
// Optional log compression is selected with `define SPECW_LOG_COMPRESS_EN (linear mode otherwise).
module spectrogram_col_writer #(
    parameter int unsigned FFT_LEN = 1024,
    parameter int unsigned N_BINS  = 512,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned IN_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic signed [IN_W-1:0]   s_re,
    input  logic signed [IN_W-1:0]   s_im,
    input  logic                     s_last,
    input  logic                     freeze,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [9:0]               ram_wr_data,
    output logic                     ram_wr_en,
    output logic                     frame_done,
    output logic                     frame_err
);

    localparam int unsigned CNT_W = $clog2(FFT_LEN);
    localparam int unsigned OUT_W = 10;

    typedef enum logic [1:0] {SYNC, WRITE, SKIP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                v1_q, v1_d, done1_q, done1_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic [IN_W-1:0]     a_q, a_d, b_q, b_d;

    logic                v2_q, v2_d, done2_q, done2_d;
    logic [ADDR_W-1:0]   addr2_q, addr2_d;
    logic [IN_W-1:0]     mag_q, mag_d;

    logic                wr_en_q, wr_en_d, done_q, done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [OUT_W-1:0]    data_q, data_d;
    logic [OUT_W-1:0]    comp;

    logic                in_range, at_end;
    logic [IN_W-1:0]     re_u, im_u;

    // Frame tracking and stage-0 write decision
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        v1_d     = 1'b0;
        done1_d  = 1'b0;
        in_range = (32'(cnt_q) < N_BINS);
        at_end   = (cnt_q == CNT_W'(FFT_LEN - 1));
        if (s_valid) begin
            cnt_d = s_last ? '0 : cnt_q + CNT_W'(1);
            unique case (state_q)
                SYNC: begin
                    if (s_last) state_d = freeze ? SKIP : WRITE;
                end
                WRITE, SKIP: begin
                    if (s_last) begin
                        err_d   = !at_end;
                        v1_d    = (state_q == WRITE) && in_range;
                        done1_d = (state_q == WRITE);
                        state_d = freeze ? SKIP : WRITE;
                    end else if (at_end) begin
                        // overlong frame: resynchronise, no frame_done for it
                        err_d   = 1'b1;
                        state_d = SYNC;
                    end else begin
                        v1_d = (state_q == WRITE) && in_range;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    // S1: absolute values (two's complement, 0x8000 maps to 32768)
    always_comb begin
        re_u    = s_re;
        im_u    = s_im;
        addr1_d = ADDR_W'(cnt_q);
        a_d     = re_u[IN_W-1] ? (~re_u + IN_W'(1)) : re_u;
        b_d     = im_u[IN_W-1] ? (~im_u + IN_W'(1)) : im_u;
    end

    // S2: alpha-max + beta-min magnitude
    always_comb begin
        v2_d    = v1_q;
        done2_d = done1_q;
        addr2_d = addr1_q;
        if (a_q >= b_q) mag_d = a_q + (b_q >> 1);
        else            mag_d = b_q + (a_q >> 1);
    end

`ifdef SPECW_LOG_COMPRESS_EN
    logic [3:0]      lead;
    logic [IN_W-1:0] norm;
    logic            unused_norm;

    // Log compression: leading-one exponent plus 6 mantissa bits below it
    always_comb begin
        lead = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (mag_q[i]) lead = 4'(i);
        end
        norm = mag_q << (4'(IN_W - 1) - lead);
        comp = (mag_q == '0) ? '0 : {lead, norm[IN_W-2 -: 6]};
    end
    assign unused_norm = ^{norm[IN_W-1], norm[IN_W-8:0]};
`else
    logic unused_mag;

    always_comb begin
        comp = mag_q[IN_W-1 -: OUT_W];
    end
    assign unused_mag = ^mag_q[IN_W-OUT_W-1:0];
`endif

    // S3: RAM port A registers; address/data hold between writes
    always_comb begin
        wr_en_d = v2_q;
        done_d  = done2_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (v2_q) begin
            addr_d = addr2_q;
            data_d = comp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            v1_q    <= 1'b0;
            done1_q <= 1'b0;
            addr1_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            v2_q    <= 1'b0;
            done2_q <= 1'b0;
            addr2_q <= '0;
            mag_q   <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            v1_q    <= v1_d;
            done1_q <= done1_d;
            addr1_q <= addr1_d;
            a_q     <= a_d;
            b_q     <= b_d;
            v2_q    <= v2_d;
            done2_q <= done2_d;
            addr2_q <= addr2_d;
            mag_q   <= mag_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign ram_addr    = addr_q;
    assign ram_wr_data = data_q;
    assign ram_wr_en   = wr_en_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;

endmodule

// File: doc/spectrogram_col_writer.md
# spectrogram_col_writer

Upstream feeder for the 512 x 10-bit spectrogram dual-port RAM. It consumes the FFT output stream (signed re/im, one bin per beat, 1024 bins per frame) and computes an approximate magnitude for each bin. The magnitude is compressed to 10 bits and written for bins 0..511 through the RAM's port A, one write per cycle. The display side reads the RAM through port B. The block also tracks frame alignment, supports freezing the display, and flags malformed frames.

## Interface
Parameters:
- FFT_LEN, 1024: FFT bins per frame, i.e. beats between s_last pulses.
- N_BINS, 512: bins written to RAM, 0..N_BINS-1. Must satisfy N_BINS <= FFT_LEN.
- ADDR_W, 9: RAM address width. 2^ADDR_W >= N_BINS.
- IN_W, 16: width of s_re and s_im. The arithmetic rules below are stated for 16.

Ports:
- clk  in  1  single clock; also drives RAM port A clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  FFT beat valid. There is no backpressure: every valid beat is consumed.
- s_re  in  IN_W  signed real part.
- s_im  in  IN_W  signed imaginary part.
- s_last  in  1  qualified by s_valid; marks bin FFT_LEN-1.
- freeze  in  1  level input. While high, new frames are not written. Sampled only at frame boundaries.
- ram_addr  out  ADDR_W  RAM port A address.
- ram_wr_data  out  10  RAM port A write data.
- ram_wr_en  out  1  RAM port A write enable.
- frame_done  out  1  one-cycle pulse: a written frame has completed.
- frame_err  out  1  one-cycle pulse: a framing error was detected.

## Operation
- Bin counter `cnt` (log2 FFT_LEN bits) counts accepted beats.
  - Clears to 0 on any beat with s_last.
  - Otherwise increments on each s_valid.
- FSM states: SYNC, WRITE, SKIP. Reset enters SYNC.
  - SYNC: discard all beats. On a beat with s_last, go to SKIP if freeze=1, else WRITE.
  - WRITE: each beat with cnt < N_BINS issues a write (address = cnt) through the pipeline. Beats with cnt >= N_BINS are dropped.
    - On s_last: schedule a frame_done pulse, then choose WRITE or SKIP from freeze.
  - SKIP: no writes. On s_last, choose WRITE or SKIP from freeze.
- Framing error, in WRITE or SKIP:
  - s_last arrives with cnt != FFT_LEN-1: pulse frame_err. That beat is still treated as a boundary, so the normal state transition applies.
  - cnt == FFT_LEN-1 without s_last: pulse frame_err, go to SYNC, and cancel the frame_done for that frame.
  - Writes already in the pipeline complete.
- Magnitude (alpha-max + beta-min):
  - a = |s_re|, b = |s_im|, as 16-bit unsigned; |-32768| = 32768.
  - mag = max(a,b) + (min(a,b) >> 1), 16-bit unsigned, maximum 49152, so it never overflows.
- Compression: see Configuration. Output is always 10 bits.

## Timing
- Pipeline is 3 stages:
  - S1 registers a and b.
  - S2 registers mag.
  - S3 registers ram_addr, ram_wr_data and ram_wr_en.
- ram_wr_en is asserted exactly 3 cycles after the accepted beat, with back-to-back writes at one per cycle. A gap in s_valid produces an identical gap in ram_wr_en.
- frame_done is asserted 3 cycles after the s_last beat of a WRITE frame, so it coincides with that beat's slot. If N_BINS < FFT_LEN, that slot carries no write.
- frame_err is asserted 1 cycle after the offending beat.
- freeze is sampled only on an s_last beat. A change mid-frame never truncates a frame.
- Reset state: ram_addr=0, ram_wr_data=0, ram_wr_en=0, frame_done=0, frame_err=0, cnt=0, state=SYNC, pipeline valids cleared.
  - Reset mid-frame: no ram_wr_en from the cycle after rst is sampled.
  - Writing resumes only after a fresh s_last.

## Configuration
- Macro SPECW_LOG_COMPRESS_EN.
- Defined (log mode):
  - If mag == 0, ram_wr_data = 0.
  - Otherwise e = index of the leading one (0..15) and m = the 6 bits immediately below it, zero-filled if e < 6.
  - ram_wr_data = {e[3:0], m[5:0]}.
  - Examples: mag=1 -> 0x000, mag=0x0003 -> 0x060, mag=0xC000 -> 0x3E0.
- Undefined (linear mode): ram_wr_data = mag[15:6]. Maximum 768; no saturation is needed.
- Latency is identical in both modes.

## Test plan
- Alignment after reset: deassert rst, send 1024 beats (last with s_last), then one full frame of re=bin index, im=0. Required: zero writes for the first frame; 512 writes at addr 0..511 in the second; frame_done 3 cycles after the second s_last.
- Magnitude and compression: re=-32768, im=32767. Required: mag=49151 (0xBFFF); log -> 0x3DF, linear -> 0x2FF. Also re=im=0 -> 0x000 in both modes.
- Freeze at boundary: raise freeze mid-frame 3. Required: frame 3 fully written. Frame 4 produces no writes and no frame_done. Dropping freeze mid-frame 4 resumes writes in frame 5.
- Short frame: s_last at cnt=300. Required: frame_err 1 cycle later, 301 writes, frame_done. The next frame is written normally from addr 0.
- Missing s_last: 1024 beats without s_last. Required: frame_err, no frame_done, state SYNC. The following frame is discarded.
- Reset mid-frame at bin 100, plus s_valid gaps: ram_wr_en low from the cycle after reset. With gaps, the write pattern mirrors the s_valid pattern with a 3-cycle delay.
